// File: rtl/residue7_sched.sv
// residue7_sched: round-robin front end feeding a serial 3-bit-per-cycle mod-7 folder.
// Define RES7_CANON_EN to report canonical residues 0..6 instead of raw 0..7.
module residue7_sched #(
    parameter int S    = 48,
    parameter int NREQ = 2,
    localparam int TW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int NSTEP = S / 3,
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*S-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_res,
    output logic [TW-1:0]     out_tag,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [S-1:0]    sh_q, sh_d;
    logic [2:0]      acc_q, acc_d;
    logic [2:0]      res_q, res_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [TW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            gnt_vld;
    logic [TW-1:0]   gnt_idx;
    logic [S-1:0]    gnt_data;
    logic [2:0]      chunk;
    logic [3:0]      sum;
    logic [2:0]      fold;

    // Two passes: indices above last_grant first, then wrap to the rest.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req_valid[i] && (TW'(i) > last_q)) begin
                gnt_vld  = 1'b1;
                gnt_idx  = TW'(i);
                gnt_data = req_data[i*S +: S];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_vld && req_valid[i] && (TW'(i) <= last_q)) begin
                gnt_vld  = 1'b1;
                gnt_idx  = TW'(i);
                gnt_data = req_data[i*S +: S];
            end
        end
    end

    // 8 == 1 mod 7, so folding a chunk is an end-around-carry add.
    assign chunk = sh_q[S-1 -: 3];
    assign sum   = {1'b0, acc_q} + {1'b0, chunk};
    assign fold  = sum[2:0] + {2'b00, sum[3]};

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        res_d     = res_q;
        tag_d     = tag_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    req_ready[gnt_idx] = 1'b1;
                    sh_d    = gnt_data;
                    acc_d   = 3'd0;
                    tag_d   = gnt_idx;
                    last_d  = gnt_idx;
                    cnt_d   = CW'(NSTEP - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d  = sh_q << 3;
                acc_d = fold;
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef RES7_CANON_EN
                    res_d = (fold == 3'd7) ? 3'd0 : fold;
`else
                    res_d = fold;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= 3'd0;
            res_q   <= 3'd0;
            tag_q   <= '0;
            last_q  <= TW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_tag   = tag_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_residue7_sched.sv
// tb_residue7_sched: scoreboard bench for residue7_sched.
// Directed latency/contention/backpressure/reset cases plus a random regression.
module tb_residue7_sched;

    localparam int S    = 48;
    localparam int NREQ = 2;
    localparam int TW   = 1;

    typedef struct packed {
        logic [2:0]    res;
        logic [TW-1:0] tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*S-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_res;
    logic [TW-1:0]     out_tag;
    logic              busy;

    logic              v [NREQ];
    logic [S-1:0]      d [NREQ];
    logic              dir_rdy = 1'b1;
    logic              rnd_rdy = 1'b1;
    logic              rand_mode = 1'b0;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   acc_log[$];

    residue7_sched #(.S(S), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_data[i*S +: S] = d[i];
        end
    end

    assign out_ready = rand_mode ? rnd_rdy : dir_rdy;

    function automatic logic [2:0] model(input logic [S-1:0] a);
        logic [63:0] m;
        logic [2:0]  r;
        m = 64'(a) % 64'd7;
        r = m[2:0];
`ifndef RES7_CANON_EN
        if (a != '0 && r == 3'd0) r = 3'd7;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic issue(input int i, input logic [S-1:0] a, input bit push);
        bit   ok;
        exp_t e;
        ok   = 1'b0;
        v[i] = 1'b1;
        d[i] = a;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                acc_log.push_back(i);
                if (push) begin
                    e.res = model(a);
                    e.tag = TW'(i);
                    exp_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        v[i] = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic latency_chk(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
        chk(name, 64'(n), 64'(S / 3));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops one expectation per handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_res", 64'(out_res), 64'(e.res));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S-1:0] a;
        logic [63:0]  r;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0;
            d[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", 64'(out_res), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single requester with latency.
        issue(0, 48'd100, 1'b1);
        latency_chk("lat_100");
        drain();
        issue(0, 48'd1000, 1'b1);
        latency_chk("lat_1000");
        drain();
        issue(0, 48'd7, 1'b1);
        drain();
        issue(0, 48'hFFFF_FFFF_FFFF, 1'b1);
        drain();
        issue(0, 48'd0, 1'b1);
        drain();

        // Contention right after reset: requester 0 first, then alternate.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        acc_log.delete();
        fork
            begin
                issue(0, 48'd123456, 1'b1);
                issue(0, 48'd777, 1'b1);
            end
            begin
                issue(1, 48'd98765, 1'b1);
                issue(1, 48'd55, 1'b1);
            end
        join
        drain();
        chk("rr_count", 64'(acc_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < acc_log.size(); k++)
            chk("rr_order", 64'(acc_log[k]), 64'(k % 2));

        // Backpressure in DONE.
        dir_rdy = 1'b0;
        issue(0, 48'd1000, 1'b1);
        latency_chk("lat_bp");
        v[1] = 1'b1;
        d[1] = 48'd42;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_res", 64'(out_res), 64'(model(48'd1000)));
            chk("bp_tag", 64'(out_tag), 64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        v[1] = 1'b0;
        dir_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        // Reset mid-RUN, in-flight result discarded.
        issue(1, 48'd999, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_res", 64'(out_res), 64'd0);
        chk("mid_rst_tag", 64'(out_tag), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 48'd100, 1'b1);
        latency_chk("lat_after_rst");
        drain();

        // Random regression.
        rand_mode = 1'b1;
        fork
            for (int i = 0; i < NREQ; i++) begin
                automatic int ri = i;
                fork
                    begin
                        logic [S-1:0] ra;
                        logic [63:0]  rr;
                        int           n;
                        for (int k = 0; k < 1000; k++) begin
                            n = $urandom_range(0, 2);
                            repeat (n) @(posedge clk);
                            if (n != 0) #1;
                            rr = {$urandom(), $urandom()};
                            case ($urandom_range(0, 9))
                                0:       ra = '0;
                                1:       ra = '1;
                                2:       ra = S'(rr[39:0] * 64'd7);
                                default: ra = rr[S-1:0];
                            endcase
                            issue(ri, ra, 1'b1);
                        end
                    end
                join_none
            end
        join
        wait fork;
        drain();
        rand_mode = 1'b0;
        a = 48'd0;
        r = 64'd0;
        chk("final_queue", 64'(exp_q.size()) + r + 64'(a), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
